// File: rtl/ps2_key_event_decoder_if.sv
// Byte-stream input and key/event output bundle for ps2_key_event_decoder.
// The decoder connects to the slave side; the master side feeds bytes and consumes events.
interface ps2_key_event_decoder_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    logic                          byte_valid;
    logic [7:0]                    byte_data;
    logic                          evt_rd;
    logic                          ovf_clr;
    logic [511:0]                  key_down;
    logic [8:0]                    last_change;
    logic                          key_valid;
    logic [8:0]                    evt_code;
    logic                          evt_break;
    logic                          evt_empty;
    logic                          evt_full;
    logic [$clog2(FIFO_DEPTH):0]   evt_count;
    logic                          evt_overflow;

    modport master (
        output byte_valid, byte_data, evt_rd, ovf_clr,
        input  key_down, last_change, key_valid,
        input  evt_code, evt_break, evt_empty, evt_full, evt_count, evt_overflow
    );

    modport slave (
        input  byte_valid, byte_data, evt_rd, ovf_clr,
        output key_down, last_change, key_valid,
        output evt_code, evt_break, evt_empty, evt_full, evt_count, evt_overflow
    );
endinterface

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 scan-code decoder: resolves E0/F0 prefixes, keeps the 512-bit key map,
// filters typematic repeats and queues make/break events in a first-word-fall-through FIFO.
module ps2_key_event_decoder #(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter bit          FILTER_REPEAT = 1'b1,
    parameter bit          CLR_ON_BAT    = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    ps2_key_event_decoder_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

    state_t       state_q, state_d;
    logic         commit, is_break, is_ext, bat_clr, evt;
    logic [8:0]   code;
    logic [511:0] key_down_q;
    logic [8:0]   last_change_q;
    logic         key_valid_q;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          empty, full, pop, wr_en, drop, overflow_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        commit   = 1'b0;
        is_break = 1'b0;
        is_ext   = 1'b0;
        bat_clr  = 1'b0;
        if (bus.byte_valid) begin
            case (state_q)
                S_IDLE: begin
                    case (bus.byte_data)
                        8'hE0: state_d = S_E0;
                        8'hF0: state_d = S_F0;
                        8'hAA: bat_clr = CLR_ON_BAT;
                        8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1: ;
                        default: commit = 1'b1;
                    endcase
                end
                S_E0: begin
                    case (bus.byte_data)
                        8'hF0: state_d = S_E0F0;
                        8'hE0: state_d = S_E0;
                        8'h12, 8'h59: state_d = S_IDLE;
                        default: begin
                            commit  = 1'b1;
                            is_ext  = 1'b1;
                            state_d = S_IDLE;
                        end
                    endcase
                end
                S_F0: begin
                    commit   = 1'b1;
                    is_break = 1'b1;
                    state_d  = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    if (bus.byte_data != 8'h12 && bus.byte_data != 8'h59) begin
                        commit   = 1'b1;
                        is_break = 1'b1;
                        is_ext   = 1'b1;
                    end
                end
            endcase
        end
    end

    assign code = {is_ext, bus.byte_data};
    // A make for a key already held is a typematic repeat and is swallowed entirely.
    assign evt  = commit && !(FILTER_REPEAT && !is_break && key_down_q[code]);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_down_q    <= '0;
            last_change_q <= '0;
            key_valid_q   <= 1'b0;
        end else begin
            key_valid_q <= evt;
            if (bat_clr) begin
                key_down_q <= '0;
            end else if (evt) begin
                key_down_q[code] <= !is_break;
                last_change_q    <= code;
            end
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign pop   = bus.evt_rd && !empty;
    assign wr_en = evt && (!full || pop);
    assign drop  = evt && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {code, is_break};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
            if (drop)             overflow_q <= 1'b1;
            else if (bus.ovf_clr) overflow_q <= 1'b0;
        end
    end

    assign bus.key_down     = key_down_q;
    assign bus.last_change  = last_change_q;
    assign bus.key_valid    = key_valid_q;
    // Head is forced to zero while empty so stale storage never shows on the outputs.
    assign bus.evt_code     = empty ? '0 : mem[rd_ptr][9:1];
    assign bus.evt_break    = empty ? 1'b0 : mem[rd_ptr][0];
    assign bus.evt_empty    = empty;
    assign bus.evt_full     = full;
    assign bus.evt_count    = count_q;
    assign bus.evt_overflow = overflow_q;
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: scoreboard model on a depth-8 filtering instance,
// plus hand sequences on a depth-4 non-filtering instance.
module tb_ps2_key_event_decoder;
    localparam int unsigned DA = 8;
    localparam int unsigned DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_key_event_decoder_if #(.FIFO_DEPTH(DA)) ba ();
    ps2_key_event_decoder_if #(.FIFO_DEPTH(DB)) bb ();

    ps2_key_event_decoder #(.FIFO_DEPTH(DA), .FILTER_REPEAT(1'b1), .CLR_ON_BAT(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(ba));
    ps2_key_event_decoder #(.FIFO_DEPTH(DB), .FILTER_REPEAT(1'b0), .CLR_ON_BAT(1'b1))
        dut_b (.clk(clk), .rst(rst), .bus(bb));

    int n_checks = 0;
    int n_pass   = 0;

    // reference model for dut_a
    logic [511:0] m_kd;
    logic [8:0]   m_last;
    logic         m_kv;
    logic         m_ovf;
    int           m_st;
    logic [9:0]   m_q[$];

    int b_pulses;

    typedef struct {
        int         n;
        logic [7:0] b0, b1, b2;
        bit         ev;
        logic [8:0] code;
        bit         brk;
    } vec_t;

    function automatic vec_t mk(int n, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                bit ev, logic [8:0] code, bit brk);
        vec_t v;
        v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.ev = ev; v.code = code; v.brk = brk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_map(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic decode(input logic [7:0] b, input int st, output int nst, output bit cmt,
                          output bit brk, output bit ext, output bit bat);
        nst = 0; cmt = 0; brk = 0; ext = 0; bat = 0;
        if (st == 0) begin
            if (b == 8'hE0) nst = 1;
            else if (b == 8'hF0) nst = 2;
            else if (b == 8'hAA) bat = 1;
            else if (!(b inside {8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1})) cmt = 1;
        end else if (st == 1) begin
            if (b == 8'hF0) nst = 3;
            else if (b == 8'hE0) nst = 1;
            else if (!(b inside {8'h12, 8'h59})) begin cmt = 1; ext = 1; end
        end else if (st == 2) begin
            cmt = 1; brk = 1;
        end else if (!(b inside {8'h12, 8'h59})) begin
            cmt = 1; brk = 1; ext = 1;
        end
    endtask

    task automatic compare_a();
        chk("key_valid", ba.key_valid, m_kv);
        chk("last_change", ba.last_change, m_last);
        chk_map("key_down", ba.key_down, m_kd);
        chk("evt_count", ba.evt_count, m_q.size());
        chk("evt_empty", ba.evt_empty, m_q.size() == 0);
        chk("evt_full", ba.evt_full, m_q.size() == DA);
        chk("evt_overflow", ba.evt_overflow, m_ovf);
        if (m_q.size() > 0) chk("evt_head", {ba.evt_code, ba.evt_break}, m_q[0]);
    endtask

    // Drive one cycle on dut_a, step the model with the same inputs, compare after the edge.
    task automatic cycle_a(input bit bv, input logic [7:0] bd, input bit rd, input bit oc);
        int nst, sz;
        bit cmt, brk, ext, bat, ev, popd;
        logic [8:0] c;
        ba.byte_valid = bv; ba.byte_data = bd; ba.evt_rd = rd; ba.ovf_clr = oc;
        sz = m_q.size();
        popd = rd && sz > 0;
        ev = 0; nst = m_st; c = '0; brk = 0;
        if (bv) begin
            decode(bd, m_st, nst, cmt, brk, ext, bat);
            c = {ext, bd};
            if (bat) m_kd = '0;
            if (cmt && (brk || !m_kd[c])) ev = 1;
        end
        if (popd) void'(m_q.pop_front());
        m_kv = ev;
        if (ev) begin
            m_kd[c] = !brk;
            m_last = c;
            if (sz < DA || popd) m_q.push_back({c, brk});
        end
        if (ev && sz == DA && !popd) m_ovf = 1;
        else if (oc) m_ovf = 0;
        m_st = nst;
        @(posedge clk); #1;
        compare_a();
    endtask

    task automatic cycle_b(input bit bv, input logic [7:0] bd, input bit rd);
        bb.byte_valid = bv; bb.byte_data = bd; bb.evt_rd = rd; bb.ovf_clr = 1'b0;
        @(posedge clk); #1;
        if (bb.key_valid) b_pulses++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ba.byte_valid = 0; ba.byte_data = '0; ba.evt_rd = 0; ba.ovf_clr = 0;
        bb.byte_valid = 0; bb.byte_data = '0; bb.evt_rd = 0; bb.ovf_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        m_kd = '0; m_last = '0; m_kv = 0; m_ovf = 0; m_st = 0; m_q.delete();
        chk_map("rst_key_down", ba.key_down, '0);
        chk("rst_last_change", ba.last_change, 0);
        chk("rst_key_valid", ba.key_valid, 0);
        chk("rst_evt_empty", ba.evt_empty, 1);
        chk("rst_evt_full", ba.evt_full, 0);
        chk("rst_evt_count", ba.evt_count, 0);
        chk("rst_evt_code", {ba.evt_code, ba.evt_break}, 0);
        chk("rst_evt_overflow", ba.evt_overflow, 0);
        chk("rst_b_empty", bb.evt_empty, 1);
        rst = 1'b0;
    endtask

    task automatic drain_a();
        int guard = 0;
        while (ba.evt_empty !== 1'b1 && guard < 2 * DA) begin
            cycle_a(0, 8'h00, 1, 0);
            guard++;
        end
        chk("drain_empty", ba.evt_empty, 1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[13];
        logic [7:0] seq[3];
        int seen;
        logic [8:0] seen_code;

        tbl[0]  = mk(1, 8'h1C, 8'h00, 8'h00, 1, 9'h01C, 0);
        tbl[1]  = mk(2, 8'hE0, 8'h75, 8'h00, 1, 9'h175, 0);
        tbl[2]  = mk(3, 8'hE0, 8'hF0, 8'h75, 1, 9'h175, 1);
        tbl[3]  = mk(2, 8'hE0, 8'h12, 8'h00, 0, 9'h000, 0);
        tbl[4]  = mk(3, 8'hE0, 8'hF0, 8'h12, 0, 9'h000, 0);
        tbl[5]  = mk(1, 8'h1C, 8'h00, 8'h00, 0, 9'h000, 0);
        tbl[6]  = mk(2, 8'hF0, 8'h1C, 8'h00, 1, 9'h01C, 1);
        tbl[7]  = mk(3, 8'hE0, 8'hE0, 8'h1F, 1, 9'h11F, 0);
        tbl[8]  = mk(1, 8'hFA, 8'h00, 8'h00, 0, 9'h000, 0);
        tbl[9]  = mk(2, 8'hF0, 8'h00, 8'h00, 1, 9'h000, 1);
        tbl[10] = mk(2, 8'hE0, 8'h59, 8'h00, 0, 9'h000, 0);
        tbl[11] = mk(3, 8'hE0, 8'hF0, 8'h59, 0, 9'h000, 0);
        tbl[12] = mk(1, 8'h29, 8'h00, 8'h00, 1, 9'h029, 0);

        do_reset();

        // dut_b: no repeat filter, depth 4
        b_pulses = 0;
        cycle_b(1, 8'h1C, 0); cycle_b(1, 8'h1C, 0); cycle_b(1, 8'h1C, 0);
        cycle_b(1, 8'hF0, 0); cycle_b(1, 8'h1C, 0); cycle_b(0, 8'h00, 0);
        chk("b_nofilter_pulses", b_pulses, 4);
        chk("b_count_full", bb.evt_count, 4);
        chk("b_full", bb.evt_full, 1);
        chk("b_ovf_clear", bb.evt_overflow, 0);
        cycle_b(1, 8'h2A, 0); cycle_b(0, 8'h00, 0);
        chk("b_drop_pulse", b_pulses, 5);
        chk("b_ovf_set", bb.evt_overflow, 1);
        chk("b_count_drop", bb.evt_count, 4);
        chk("b_key_after_drop", bb.key_down[9'h02A], 1);
        chk("b_head0", {bb.evt_code, bb.evt_break}, {9'h01C, 1'b0});
        cycle_b(1, 8'h33, 1); cycle_b(0, 8'h00, 0);
        chk("b_count_pushpop", bb.evt_count, 4);
        chk("b_head1", {bb.evt_code, bb.evt_break}, {9'h01C, 1'b0});
        cycle_b(0, 8'h00, 1);
        chk("b_head2", {bb.evt_code, bb.evt_break}, {9'h01C, 1'b0});
        cycle_b(0, 8'h00, 1);
        chk("b_head3", {bb.evt_code, bb.evt_break}, {9'h01C, 1'b1});
        cycle_b(0, 8'h00, 1);
        chk("b_head4", {bb.evt_code, bb.evt_break}, {9'h033, 1'b0});
        cycle_b(0, 8'h00, 1);
        chk("b_drained", bb.evt_empty, 1);
        cycle_b(0, 8'h00, 0);

        // dut_a: table of byte sequences
        foreach (tbl[i]) begin
            seq[0] = tbl[i].b0; seq[1] = tbl[i].b1; seq[2] = tbl[i].b2;
            seen = 0; seen_code = '0;
            for (int j = 0; j < tbl[i].n; j++) begin
                cycle_a(1, seq[j], 0, 0);
                if (ba.key_valid) begin seen++; seen_code = ba.last_change; end
            end
            cycle_a(0, 8'h00, 0, 0);
            chk($sformatf("vec%0d_events", i), seen, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_code", i), seen_code, tbl[i].code);
                chk($sformatf("vec%0d_keybit", i), ba.key_down[tbl[i].code], !tbl[i].brk);
            end
        end
        chk("first_evt_head", {ba.evt_code, ba.evt_break}, {9'h01C, 1'b0});
        drain_a();

        // typematic filter with repeat
        seen = 0;
        foreach (seq[j]) seq[j] = 8'h1C;
        for (int j = 0; j < 3; j++) begin cycle_a(1, 8'h1C, 0, 0); if (ba.key_valid) seen++; end
        cycle_a(1, 8'hF0, 0, 0); if (ba.key_valid) seen++;
        cycle_a(1, 8'h1C, 0, 0); if (ba.key_valid) seen++;
        cycle_a(0, 8'h00, 0, 0);
        chk("filter_events", seen, 2);
        chk("filter_count", ba.evt_count, 2);
        drain_a();

        // overflow on depth 8
        for (int k = 0; k < 9; k++) cycle_a(1, 8'h15 + 8'(k), 0, 0);
        cycle_a(0, 8'h00, 0, 0);
        chk("a_full", ba.evt_full, 1);
        chk("a_ovf", ba.evt_overflow, 1);
        chk("a_count_full", ba.evt_count, 8);
        chk("a_dropped_key_down", ba.key_down[9'h01D], 1);
        cycle_a(1, 8'h2C, 1, 0);
        chk("a_pushpop_full", ba.evt_count, 8);
        cycle_a(1, 8'h2D, 0, 1);
        chk("a_ovf_set_wins", ba.evt_overflow, 1);
        cycle_a(0, 8'h00, 0, 1);
        chk("a_ovf_cleared", ba.evt_overflow, 0);
        drain_a();

        // BAT clears the key map
        cycle_a(1, 8'h1C, 0, 0);
        cycle_a(1, 8'hAA, 0, 0);
        chk("bat_no_pulse", ba.key_valid, 0);
        chk_map("bat_clear", ba.key_down, '0);
        drain_a();

        // reset discards a held E0 prefix
        cycle_a(1, 8'hE0, 0, 0);
        do_reset();
        cycle_a(1, 8'h1C, 0, 0);
        chk("post_rst_code", ba.last_change, 9'h01C);
        chk("post_rst_pulse", ba.key_valid, 1);
        drain_a();

        // random byte stream against the model
        for (int k = 0; k < 500; k++) begin
            int r;
            logic [7:0] bd;
            r = $urandom_range(0, 31);
            if (r < 3) bd = 8'hE0;
            else if (r < 6) bd = 8'hF0;
            else if (r == 6) bd = 8'h12;
            else if (r == 7) bd = 8'h59;
            else if (r == 8) bd = 8'hFA;
            else if (r == 9 && $urandom_range(0, 3) == 0) bd = 8'hAA;
            else bd = 8'h10 + 8'($urandom_range(0, 11));
            cycle_a($urandom_range(0, 2) != 0, bd, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 19) == 0);
        end
        drain_a();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
